// File: rtl/dispatch_pkg.sv
// dispatch_pkg: decoded-entry type, mem_type codes and load/store classification for issue_dispatch
package dispatch_pkg;
  localparam logic [2:0] ST_W = 3'b001;
  localparam logic [2:0] LD_B = 3'b010;
  localparam logic [2:0] LD_H = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] ST_B = 3'b110;
  localparam logic [2:0] ST_H = 3'b111;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [1:0]  src_sel1;
    logic [1:0]  src_sel2;
    logic [11:0] alu_op;
    logic [3:0]  br_type;
    logic        br_pd;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        mem_we;
    logic [2:0]  mem_type;
  } dec_entry_t;
  function automatic logic is_load(input logic [2:0] t);
    return t inside {LD_B, LD_H, LD_BU, LD_HU};
  endfunction
  function automatic logic is_store(input logic [2:0] t);
    return t inside {ST_W, ST_B, ST_H};
  endfunction
  function automatic logic is_mem(input logic [2:0] t);
    return is_load(t) || is_store(t);
  endfunction
endpackage

// File: rtl/dispatch_queue.sv
// dispatch_queue: circular buffer with 2 in-order write ports (enq), 2 head read ports (rdata0/1), dequeue of 0-2 (deq), flush and occupancy count
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       enq,
  input  logic [1:0]       deq,
  input  dec_entry_t       wdata0,
  input  dec_entry_t       wdata1,
  output dec_entry_t       rdata0,
  output dec_entry_t       rdata1,
  output logic [PTR_W:0]   count
);
  dec_entry_t mem [DEPTH];
  logic [PTR_W:0] head, tail, head1, tail1;
  assign count = tail - head;
  assign head1 = head + (PTR_W+1)'(1);
  assign tail1 = tail + (PTR_W+1)'(enq[0]);
  assign rdata0 = count != '0 ? mem[head[PTR_W-1:0]] : dec_entry_t'('0);
  assign rdata1 = count > (PTR_W+1)'(1) ? mem[head1[PTR_W-1:0]] : dec_entry_t'('0);
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + (PTR_W+1)'(deq);
      tail <= tail1 + (PTR_W+1)'(enq[1]);
    end
  always_ff @(posedge clk) begin
    if (enq[0]) mem[tail[PTR_W-1:0]] <= wdata0;
    if (enq[1]) mem[tail1[PTR_W-1:0]] <= wdata1;
  end
endmodule

// File: rtl/issue_dispatch.sv
// issue_dispatch: dual-issue dispatch; queues decode slots, picks lanes A/B, reads RF (rf_raddr/rf_rdata), registers EX_* packets
module issue_dispatch
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  in_valid,
  input  dec_entry_t  in_entry0,
  input  dec_entry_t  in_entry1,
  output logic        in_ready,
  input  logic        stall,
  input  logic        EX_br,
  output logic [4:0]  rf_raddr_a1,
  output logic [4:0]  rf_raddr_a2,
  output logic [4:0]  rf_raddr_b1,
  output logic [4:0]  rf_raddr_b2,
  input  logic [31:0] rf_rdata_a1,
  input  logic [31:0] rf_rdata_a2,
  input  logic [31:0] rf_rdata_b1,
  input  logic [31:0] rf_rdata_b2,
  output logic [31:0] EX_pc_a,
  output logic [31:0] EX_pc_b,
  output logic [31:0] EX_imm_a,
  output logic [31:0] EX_imm_b,
  output logic [31:0] EX_rf_rdata_a1,
  output logic [31:0] EX_rf_rdata_a2,
  output logic [31:0] EX_rf_rdata_b1,
  output logic [31:0] EX_rf_rdata_b2,
  output logic [4:0]  EX_rf_raddr_a1,
  output logic [4:0]  EX_rf_raddr_a2,
  output logic [4:0]  EX_rf_raddr_b1,
  output logic [4:0]  EX_rf_raddr_b2,
  output logic [1:0]  EX_alu_src_sel_a1,
  output logic [1:0]  EX_alu_src_sel_a2,
  output logic [1:0]  EX_alu_src_sel_b1,
  output logic [1:0]  EX_alu_src_sel_b2,
  output logic [11:0] EX_alu_op_a,
  output logic [11:0] EX_alu_op_b,
  output logic [3:0]  EX_br_type_a,
  output logic [3:0]  EX_br_type_b,
  output logic        EX_br_pd_a,
  output logic        EX_br_pd_b,
  output logic        EX_rf_we_a,
  output logic        EX_rf_we_b,
  output logic [4:0]  EX_rf_waddr_a,
  output logic [4:0]  EX_rf_waddr_b,
  output logic        EX_mem_we_a,
  output logic        EX_mem_we_b,
  output logic [2:0]  EX_mem_type_a,
  output logic [2:0]  EX_mem_type_b
);
  localparam dec_entry_t BUBBLE = '0;
  dec_entry_t c0, c1, lane_a, lane_b, ex_a, ex_b;
  logic [PTR_W:0] count;
  logic [5:0] ld_ex, ld_mem;
  logic [3:0][31:0] ex_rd;
  logic go, flush, v1, iss0, ld0, pair, raw;
  logic [1:0] enq, deq;
  function automatic logic hit(input logic [4:0] a, input logic [5:0] s);
    return s[5] && s[4:0] != '0 && s[4:0] == a;
  endfunction
  function automatic logic hazard(input dec_entry_t e, input logic [5:0] x, input logic [5:0] y);
    return hit(e.raddr1, x) || hit(e.raddr1, y) || hit(e.raddr2, x) || hit(e.raddr2, y);
  endfunction
  assign go = !stall && !EX_br;
  assign flush = EX_br && !stall;
  assign in_ready = count <= (PTR_W+1)'(DEPTH-2);
  assign enq = (in_ready && go) ? in_valid : 2'b00;
  dispatch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
    .clk(clk), .rst(rst), .flush(flush), .enq(enq), .deq(deq),
    .wdata0(in_entry0), .wdata1(in_entry1), .rdata0(c0), .rdata1(c1), .count(count)
  );
  assign v1 = count > (PTR_W+1)'(1);
  assign iss0 = count != '0 && !hazard(c0, ld_ex, ld_mem);
  assign ld0 = iss0 && is_load(c0.mem_type);
  assign raw = c0.rf_we && c0.waddr != '0 && (c1.raddr1 == c0.waddr || c1.raddr2 == c0.waddr);
  assign pair = iss0 && !ld0 && v1 && !(is_mem(c0.mem_type) && is_mem(c1.mem_type)) && !raw && !hazard(c1, ld_ex, ld_mem);
  assign lane_a = (iss0 && !ld0) ? c0 : BUBBLE;
  assign lane_b = ld0 ? c0 : pair ? c1 : BUBBLE;
  assign deq = go ? {1'b0, iss0} + {1'b0, pair} : 2'b00;
  assign rf_raddr_a1 = lane_a.raddr1;
  assign rf_raddr_a2 = lane_a.raddr2;
  assign rf_raddr_b1 = lane_b.raddr1;
  assign rf_raddr_b2 = lane_b.raddr2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_a <= BUBBLE;
      ex_b <= BUBBLE;
      ex_rd <= '0;
      ld_ex <= '0;
      ld_mem <= '0;
    end else if (!stall) begin
      ex_a <= EX_br ? BUBBLE : lane_a;
      ex_b <= EX_br ? BUBBLE : lane_b;
      ex_rd <= EX_br ? '0 : {rf_rdata_a1, rf_rdata_a2, rf_rdata_b1, rf_rdata_b2};
      ld_mem <= EX_br ? '0 : ld_ex;
      ld_ex <= (!EX_br && is_load(lane_b.mem_type)) ? {1'b1, lane_b.waddr} : 6'd0;
    end
  assign {EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2} = ex_rd;
  assign EX_pc_a = ex_a.pc;
  assign EX_pc_b = ex_b.pc;
  assign EX_imm_a = ex_a.imm;
  assign EX_imm_b = ex_b.imm;
  assign EX_rf_raddr_a1 = ex_a.raddr1;
  assign EX_rf_raddr_a2 = ex_a.raddr2;
  assign EX_rf_raddr_b1 = ex_b.raddr1;
  assign EX_rf_raddr_b2 = ex_b.raddr2;
  assign EX_alu_src_sel_a1 = ex_a.src_sel1;
  assign EX_alu_src_sel_a2 = ex_a.src_sel2;
  assign EX_alu_src_sel_b1 = ex_b.src_sel1;
  assign EX_alu_src_sel_b2 = ex_b.src_sel2;
  assign EX_alu_op_a = ex_a.alu_op;
  assign EX_alu_op_b = ex_b.alu_op;
  assign EX_br_type_a = ex_a.br_type;
  assign EX_br_type_b = ex_b.br_type;
  assign EX_br_pd_a = ex_a.br_pd;
  assign EX_br_pd_b = ex_b.br_pd;
  assign EX_rf_we_a = ex_a.rf_we;
  assign EX_rf_we_b = ex_b.rf_we;
  assign EX_rf_waddr_a = ex_a.waddr;
  assign EX_rf_waddr_b = ex_b.waddr;
  assign EX_mem_we_a = ex_a.mem_we;
  assign EX_mem_we_b = ex_b.mem_we;
  assign EX_mem_type_a = ex_a.mem_type;
  assign EX_mem_type_b = ex_b.mem_type;
endmodule

// File: tb/tb_issue_dispatch.sv
// tb_issue_dispatch: directed and random stimulus checked against a queue-based reference model
module tb_issue_dispatch;
  import dispatch_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, EX_br = 1'b0;
  logic [1:0] in_valid = 2'b00;
  dec_entry_t in_entry0 = '0, in_entry1 = '0;
  logic in_ready;
  logic [4:0] rf_raddr_a1, rf_raddr_a2, rf_raddr_b1, rf_raddr_b2;
  logic [31:0] rf_rdata_a1, rf_rdata_a2, rf_rdata_b1, rf_rdata_b2;
  logic [31:0] EX_pc_a, EX_pc_b, EX_imm_a, EX_imm_b;
  logic [31:0] EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2;
  logic [4:0] EX_rf_raddr_a1, EX_rf_raddr_a2, EX_rf_raddr_b1, EX_rf_raddr_b2;
  logic [1:0] EX_alu_src_sel_a1, EX_alu_src_sel_a2, EX_alu_src_sel_b1, EX_alu_src_sel_b2;
  logic [11:0] EX_alu_op_a, EX_alu_op_b;
  logic [3:0] EX_br_type_a, EX_br_type_b;
  logic EX_br_pd_a, EX_br_pd_b, EX_rf_we_a, EX_rf_we_b, EX_mem_we_a, EX_mem_we_b;
  logic [4:0] EX_rf_waddr_a, EX_rf_waddr_b;
  logic [2:0] EX_mem_type_a, EX_mem_type_b;
  int n_chk = 0, n_pass = 0;
  dec_entry_t q[$];
  logic [4:0] sb_ex = '0, sb_mem = '0;
  dec_entry_t ea = '0, eb = '0;
  logic [31:0] erd [4] = '{default: '0};
  always #5 clk = ~clk;
  function automatic logic [31:0] rf(input logic [4:0] a);
    return a == 5'd0 ? 32'h0 : ({a, 27'h0} ^ {27'h0, a} ^ 32'h1234_5600);
  endfunction
  assign rf_rdata_a1 = rf(rf_raddr_a1);
  assign rf_rdata_a2 = rf(rf_raddr_a2);
  assign rf_rdata_b1 = rf(rf_raddr_b1);
  assign rf_rdata_b2 = rf(rf_raddr_b2);
  issue_dispatch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_entry0(in_entry0), .in_entry1(in_entry1),
    .in_ready(in_ready), .stall(stall), .EX_br(EX_br),
    .rf_raddr_a1(rf_raddr_a1), .rf_raddr_a2(rf_raddr_a2), .rf_raddr_b1(rf_raddr_b1), .rf_raddr_b2(rf_raddr_b2),
    .rf_rdata_a1(rf_rdata_a1), .rf_rdata_a2(rf_rdata_a2), .rf_rdata_b1(rf_rdata_b1), .rf_rdata_b2(rf_rdata_b2),
    .EX_pc_a(EX_pc_a), .EX_pc_b(EX_pc_b), .EX_imm_a(EX_imm_a), .EX_imm_b(EX_imm_b),
    .EX_rf_rdata_a1(EX_rf_rdata_a1), .EX_rf_rdata_a2(EX_rf_rdata_a2),
    .EX_rf_rdata_b1(EX_rf_rdata_b1), .EX_rf_rdata_b2(EX_rf_rdata_b2),
    .EX_rf_raddr_a1(EX_rf_raddr_a1), .EX_rf_raddr_a2(EX_rf_raddr_a2),
    .EX_rf_raddr_b1(EX_rf_raddr_b1), .EX_rf_raddr_b2(EX_rf_raddr_b2),
    .EX_alu_src_sel_a1(EX_alu_src_sel_a1), .EX_alu_src_sel_a2(EX_alu_src_sel_a2),
    .EX_alu_src_sel_b1(EX_alu_src_sel_b1), .EX_alu_src_sel_b2(EX_alu_src_sel_b2),
    .EX_alu_op_a(EX_alu_op_a), .EX_alu_op_b(EX_alu_op_b),
    .EX_br_type_a(EX_br_type_a), .EX_br_type_b(EX_br_type_b),
    .EX_br_pd_a(EX_br_pd_a), .EX_br_pd_b(EX_br_pd_b),
    .EX_rf_we_a(EX_rf_we_a), .EX_rf_we_b(EX_rf_we_b),
    .EX_rf_waddr_a(EX_rf_waddr_a), .EX_rf_waddr_b(EX_rf_waddr_b),
    .EX_mem_we_a(EX_mem_we_a), .EX_mem_we_b(EX_mem_we_b),
    .EX_mem_type_a(EX_mem_type_a), .EX_mem_type_b(EX_mem_type_b)
  );
  function automatic bit tb_ld(input logic [2:0] t);
    return t >= 3'd2 && t <= 3'd5;
  endfunction
  function automatic bit tb_st(input logic [2:0] t);
    return t == 3'd1 || t >= 3'd6;
  endfunction
  function automatic bit reads(input dec_entry_t e, input logic [4:0] r);
    return r != 5'd0 && (e.raddr1 == r || e.raddr2 == r);
  endfunction
  function automatic bit load_use(input dec_entry_t e);
    return reads(e, sb_ex) || reads(e, sb_mem);
  endfunction
  function automatic dec_entry_t mk(input int pc, input logic [4:0] wa, input logic [4:0] r1,
                                    input logic [4:0] r2, input logic [2:0] mt);
    dec_entry_t e;
    e = '0;
    e.pc = 32'(pc);
    e.imm = 32'(pc) ^ 32'hABCD_0000;
    e.raddr1 = r1;
    e.raddr2 = r2;
    e.src_sel1 = 2'd1;
    e.src_sel2 = 2'd2;
    e.alu_op = 12'h001;
    e.mem_type = mt;
    e.mem_we = tb_st(mt);
    e.rf_we = !tb_st(mt) && wa != 5'd0;
    e.waddr = tb_st(mt) ? 5'd0 : wa;
    return e;
  endfunction
  function automatic dec_entry_t rnd();
    logic [127:0] r;
    dec_entry_t e;
    r = {$urandom, $urandom, $urandom, $urandom};
    e = r[$bits(dec_entry_t)-1:0];
    e.raddr1 = 5'($urandom_range(0, 6));
    e.raddr2 = 5'($urandom_range(0, 6));
    e.waddr = 5'($urandom_range(0, 6));
    e.mem_type = $urandom_range(0, 1) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic pick(output dec_entry_t a, output dec_entry_t b, output int n);
    a = '0;
    b = '0;
    n = 0;
    if (q.size() == 0 || load_use(q[0])) return;
    if (tb_ld(q[0].mem_type)) begin
      b = q[0];
      n = 1;
      return;
    end
    a = q[0];
    n = 1;
    if (q.size() >= 2 && !(q[0].mem_type != 0 && q[1].mem_type != 0) &&
        !(q[0].rf_we && reads(q[1], q[0].waddr)) && !load_use(q[1])) begin
      b = q[1];
      n = 2;
    end
  endtask
  task automatic clear_model();
    q.delete();
    sb_ex = '0;
    sb_mem = '0;
    ea = '0;
    eb = '0;
    erd = '{default: '0};
  endtask
  task automatic check_ex(input string tag);
    dec_entry_t ga, gb;
    ga = '{EX_pc_a, EX_imm_a, EX_rf_raddr_a1, EX_rf_raddr_a2, EX_alu_src_sel_a1, EX_alu_src_sel_a2,
           EX_alu_op_a, EX_br_type_a, EX_br_pd_a, EX_rf_we_a, EX_rf_waddr_a, EX_mem_we_a, EX_mem_type_a};
    gb = '{EX_pc_b, EX_imm_b, EX_rf_raddr_b1, EX_rf_raddr_b2, EX_alu_src_sel_b1, EX_alu_src_sel_b2,
           EX_alu_op_b, EX_br_type_b, EX_br_pd_b, EX_rf_we_b, EX_rf_waddr_b, EX_mem_we_b, EX_mem_type_b};
    chk({tag, "_ex_a"}, ga, ea);
    chk({tag, "_ex_b"}, gb, eb);
    chk({tag, "_ex_rdata"}, {EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2},
        {erd[0], erd[1], erd[2], erd[3]});
  endtask
  task automatic step(input string tag, input logic [1:0] v, input dec_entry_t e0, input dec_entry_t e1,
                      input logic s, input logic br);
    dec_entry_t a, b;
    int n;
    bit rdy;
    in_valid = v;
    in_entry0 = e0;
    in_entry1 = e1;
    stall = s;
    EX_br = br;
    #2;
    rdy = q.size() <= DEPTH - 2;
    pick(a, b, n);
    chk({tag, "_in_ready"}, in_ready, rdy);
    chk({tag, "_rf_raddr"}, {rf_raddr_a1, rf_raddr_a2, rf_raddr_b1, rf_raddr_b2},
        {a.raddr1, a.raddr2, b.raddr1, b.raddr2});
    if (!s && br) clear_model();
    else if (!s) begin
      ea = a;
      eb = b;
      erd = '{rf(a.raddr1), rf(a.raddr2), rf(b.raddr1), rf(b.raddr2)};
      sb_mem = sb_ex;
      sb_ex = tb_ld(b.mem_type) ? b.waddr : 5'd0;
      repeat (n) void'(q.pop_front());
      if (rdy && v[0]) q.push_back(e0);
      if (rdy && v[1]) q.push_back(e1);
    end
    @(posedge clk);
    #1;
    check_ex(tag);
  endtask
  task automatic idle(input string tag);
    step(tag, 2'b00, '0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    int r;
    #3;
    check_ex("reset");
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("indep", 2'b11, mk(100, 1, 0, 0, 3'd0), mk(104, 2, 0, 0, 3'd0), 1'b0, 1'b0);
    idle("indep_issue");
    chk("indep_we_pair", {EX_rf_we_a, EX_rf_we_b, EX_pc_a, EX_pc_b}, {2'b11, 32'd100, 32'd104});
    idle("indep_empty");
    chk("indep_empty_we", {EX_rf_we_a, EX_rf_we_b}, 2'b00);
    step("raw", 2'b11, mk(200, 3, 1, 2, 3'd0), mk(204, 4, 3, 3, 3'd0), 1'b0, 1'b0);
    idle("raw_first");
    chk("raw_first_lane", {EX_pc_a, EX_rf_we_b}, {32'd200, 1'b0});
    idle("raw_second");
    chk("raw_second_lane", EX_pc_a, 32'd204);
    step("lduse", 2'b11, mk(300, 5, 1, 0, LD_B), mk(304, 6, 5, 1, 3'd0), 1'b0, 1'b0);
    idle("lduse_load");
    chk("lduse_load_lane", {EX_pc_b, EX_rf_we_a, EX_mem_type_b}, {32'd300, 1'b0, LD_B});
    idle("lduse_bub1");
    chk("lduse_bub1_we", {EX_rf_we_a, EX_rf_we_b}, 2'b00);
    idle("lduse_bub2");
    idle("lduse_add");
    chk("lduse_add_lane", EX_pc_a, 32'd304);
    step("stld", 2'b11, mk(400, 0, 1, 2, ST_W), mk(404, 7, 1, 0, 3'b010), 1'b0, 1'b0);
    idle("stld_store");
    chk("stld_store_lane", {EX_pc_a, EX_mem_we_a, EX_mem_type_b}, {32'd400, 1'b1, 3'd0});
    idle("stld_load");
    chk("stld_load_lane", {EX_pc_b, EX_mem_type_b, EX_rf_we_a}, {32'd404, 3'b010, 1'b0});
    r = 1;
    for (int i = 0; i < 20 && in_ready; i++) begin
      step("fill", 2'b11, mk(500 + 8 * i, 5'(r + 1), 5'(r), 0, 3'd0),
           mk(504 + 8 * i, 5'(r + 2), 5'(r + 1), 0, 3'd0), 1'b0, 1'b0);
      r = r >= 26 ? 1 : r + 2;
    end
    chk("fill_full", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) step("hold", 2'b11, rnd(), rnd(), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("drain", 2'b01, mk(700 + 4 * i, 9, 8, 0, 3'd0), '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("preflush", 2'b11, mk(800 + 8 * i, 10, 10, 0, 3'd0), mk(804 + 8 * i, 10, 10, 0, 3'd0), 1'b0, 1'b0);
    step("flush", 2'b11, rnd(), rnd(), 1'b0, 1'b1);
    chk("flush_bubble", {in_ready, EX_rf_we_a, EX_rf_we_b, EX_mem_type_a, EX_mem_type_b}, {1'b1, 8'd0});
    idle("postflush");
    step("refill", 2'b11, mk(900, 11, 0, 0, 3'd0), mk(904, 11, 11, 0, 3'd0), 1'b0, 1'b0);
    step("brstall", 2'b00, '0, '0, 1'b1, 1'b1);
    idle("brstall_after");
    chk("brstall_issue", EX_pc_a, 32'd900);
    step("midop", 2'b11, mk(950, 12, 0, 0, 3'd0), mk(954, 13, 12, 0, 3'd0), 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    clear_model();
    check_ex("async_rst");
    chk("async_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      v = $urandom_range(0, 2) == 0 ? 2'b00 : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b11);
      step("rand", v, rnd(), rnd(), $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
